// File: rtl/mult_pkg.sv
// Shared types for the multiplier issue queue: operand record, FSM state encoding,
// default queue depth and the saturating error-counter step.
package mult_pkg;

    localparam int MULT_DEPTH = 4;

    typedef struct packed {
        logic [15:0] a;
        logic        a_parity;
        logic [15:0] b;
        logic        b_parity;
    } operand_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RES = 2'd2,
        S_DONE     = 2'd3
    } issue_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Operand queue: DEPTH-entry FIFO, head readable combinationally, push/pop same edge.
// Push ignored when full, pop ignored when empty; upstream sees full as backpressure.
module mult_op_fifo
    import mult_pkg::*;
#(
    parameter  int DEPTH = MULT_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  operand_t      push_dat_i,
    input  logic          pop_i,
    output operand_t      head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    operand_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/mult_issue_queue.sv
// Queues operand pairs and issues them one at a time to a req/ack multiplier; req follows a push into an empty idle queue by one cycle.
// in_ready drops while the queue is full; only one multiplication is in flight, the head is popped on completion.
module mult_issue_queue
    import mult_pkg::*;
#(
    parameter  int DEPTH = MULT_DEPTH,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_arg_a,
    input  logic [15:0]   in_arg_b,
    input  logic          in_arg_a_parity,
    input  logic          in_arg_b_parity,
    output logic          req,
    output logic [15:0]   arg_a,
    output logic [15:0]   arg_b,
    output logic          arg_a_parity,
    output logic          arg_b_parity,
    input  logic          ack,
    input  logic          result_rdy,
    input  logic [31:0]   result,
    input  logic          result_parity,
    input  logic          arg_parity_error,
    output logic          out_valid,
    output logic [31:0]   out_result,
    output logic          out_result_parity,
    output logic          out_parity_error,
    output logic [LW-1:0] level,
    output logic [15:0]   err_cnt
);

    issue_state_t state_q, state_d;
    operand_t     in_op, head_op, arg_q, arg_d;
    logic         req_q, req_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  out_result_q, out_result_d;
    logic         out_rpar_q, out_rpar_d;
    logic         out_perr_q, out_perr_d;
    logic [15:0]  err_cnt_q, err_cnt_d;
    logic         fifo_full, fifo_empty, pop;

    assign in_op = '{a: in_arg_a, a_parity: in_arg_a_parity,
                     b: in_arg_b, b_parity: in_arg_b_parity};

    mult_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (in_valid),
        .push_dat_i (in_op),
        .pop_i      (pop),
        .head_o     (head_op),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (level)
    );

    assign in_ready = !fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (!fifo_empty) state_d = S_REQ;
            S_REQ:      if (ack)         state_d = result_rdy ? S_DONE : S_WAIT_RES;
            S_WAIT_RES: if (result_rdy)  state_d = S_DONE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // The entry stays at the head while in flight; it is popped only in DONE.
    always_comb begin
        req_d        = req_q;
        arg_d        = arg_q;
        out_valid_d  = 1'b0;
        out_result_d = out_result_q;
        out_rpar_d   = out_rpar_q;
        out_perr_d   = out_perr_q;
        err_cnt_d    = err_cnt_q;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: if (!fifo_empty) begin
                req_d = 1'b1;
                arg_d = head_op;
            end
            S_REQ: if (ack) req_d = 1'b0;
            S_DONE: begin
                pop = 1'b1;
                if (out_perr_q) err_cnt_d = sat_inc16(err_cnt_q);
            end
            default: ;
        endcase
        if (((state_q == S_REQ) && ack && result_rdy) ||
            ((state_q == S_WAIT_RES) && result_rdy)) begin
            out_valid_d  = 1'b1;
            out_result_d = result;
            out_rpar_d   = result_parity;
            out_perr_d   = arg_parity_error;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q        <= 1'b0;
            arg_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rpar_q   <= 1'b0;
            out_perr_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            req_q        <= req_d;
            arg_q        <= arg_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rpar_q   <= out_rpar_d;
            out_perr_q   <= out_perr_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign req               = req_q;
    assign arg_a             = arg_q.a;
    assign arg_b             = arg_q.b;
    assign arg_a_parity      = arg_q.a_parity;
    assign arg_b_parity      = arg_q.b_parity;
    assign out_valid         = out_valid_q;
    assign out_result        = out_result_q;
    assign out_result_parity = out_rpar_q;
    assign out_parity_error  = out_perr_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue: operands and results are scoreboarded at issue
// time and compared by a monitor when the DUT acks an operand or pulses out_valid.
module tb_mult_issue_queue;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [15:0]   in_arg_a, in_arg_b;
    logic          in_arg_a_parity, in_arg_b_parity;
    logic          req;
    logic [15:0]   arg_a, arg_b;
    logic          arg_a_parity, arg_b_parity;
    logic          ack, result_rdy;
    logic [31:0]   result;
    logic          result_parity, arg_parity_error;
    logic          out_valid;
    logic [31:0]   out_result;
    logic          out_result_parity, out_parity_error;
    logic [LW-1:0] level;
    logic [15:0]   err_cnt;

    mult_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_arg_a(in_arg_a), .in_arg_b(in_arg_b),
        .in_arg_a_parity(in_arg_a_parity), .in_arg_b_parity(in_arg_b_parity),
        .req(req), .arg_a(arg_a), .arg_b(arg_b),
        .arg_a_parity(arg_a_parity), .arg_b_parity(arg_b_parity),
        .ack(ack), .result_rdy(result_rdy), .result(result),
        .result_parity(result_parity), .arg_parity_error(arg_parity_error),
        .out_valid(out_valid), .out_result(out_result),
        .out_result_parity(out_result_parity), .out_parity_error(out_parity_error),
        .level(level), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic        pa;
        logic [15:0] b;
        logic        pb;
    } exp_op_t;

    typedef struct packed {
        logic [31:0] res;
        logic        rpar;
        logic        perr;
        logic [15:0] err;
    } exp_res_t;

    exp_op_t     exp_ops [$];
    exp_res_t    exp_res [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_err = '0;
    logic        err_pend = 1'b0;
    logic [15:0] err_want = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: operand order checked at each accepted req, results at each out_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (err_pend) begin
                check("err_cnt_after_done", 32'(err_cnt), 32'(err_want));
                err_pend = 1'b0;
            end
            if (rst_n === 1'b1) begin
                if (req && ack) begin
                    if (exp_ops.size() == 0) check("unexpected_req", 32'(req), 32'd0);
                    else begin
                        exp_op_t o;
                        o = exp_ops.pop_front();
                        check("arg_a", 32'(arg_a), 32'(o.a));
                        check("arg_b", 32'(arg_b), 32'(o.b));
                        check("arg_parities", {30'd0, arg_a_parity, arg_b_parity}, {30'd0, o.pa, o.pb});
                    end
                end
                if (out_valid) begin
                    if (exp_res.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
                    else begin
                        exp_res_t r;
                        r = exp_res.pop_front();
                        check("out_result", out_result, r.res);
                        check("out_flags", {30'd0, out_result_parity, out_parity_error}, {30'd0, r.rpar, r.perr});
                        err_want = r.err;
                        err_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic pa, input logic [15:0] b, input logic pb);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin tick(); n++; end
        if (in_ready !== 1'b1) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_arg_a = a; in_arg_b = b;
        in_arg_a_parity = pa; in_arg_b_parity = pb;
        exp_ops.push_back('{a: a, pa: pa, b: b, pb: pb});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_req;
        int n = 0;
        while (req !== 1'b1 && n < 100) begin tick(); n++; end
        if (req !== 1'b1) check("req_timeout", 32'(req), 32'd1);
    endtask

    // Plays the multiplier: ack after ack_dly cycles of req, result res_dly cycles after ack.
    // Returns one step into the DONE cycle.
    task automatic serve(input int ack_dly, input int res_dly, input logic [31:0] r,
                         input logic rp, input logic pe);
        logic [15:0] a0;
        wait_req();
        a0 = arg_a;
        repeat (ack_dly) begin
            tick();
            check("req_held", 32'(req), 32'd1);
            check("arg_a_held", 32'(arg_a), 32'(a0));
        end
        if (pe) exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
        exp_res.push_back('{res: r, rpar: rp, perr: pe, err: exp_err});
        ack = 1'b1;
        if (res_dly == 0) begin
            result_rdy = 1'b1; result = r; result_parity = rp; arg_parity_error = pe;
        end
        tick();
        ack = 1'b0; result_rdy = 1'b0; result = '0; result_parity = 1'b0; arg_parity_error = 1'b0;
        check("req_drop_after_ack", 32'(req), 32'd0);
        if (res_dly > 0) begin
            repeat (res_dly - 1) tick();
            result_rdy = 1'b1; result = r; result_parity = rp; arg_parity_error = pe;
            tick();
            result_rdy = 1'b0; result = '0; result_parity = 1'b0; arg_parity_error = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_arg_a = '0; in_arg_b = '0;
        in_arg_a_parity = 1'b0; in_arg_b_parity = 1'b0;
        ack = 1'b0; result_rdy = 1'b0; result = '0; result_parity = 1'b0; arg_parity_error = 1'b0;
        #1;
        check("rst_req", 32'(req), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_arg_a", 32'(arg_a), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Basic transaction with minimum-latency req and out_* holding afterwards.
        push(16'h0003, 1'b0, 16'hFFFC, 1'b0);
        check("level_after_push", 32'(level), 32'd1);
        tick();
        check("req_latency", 32'(req), 32'd1);
        serve(2, 3, 32'hFFFFFFF4, 1'b0, 1'b0);
        check("done_out_valid", 32'(out_valid), 32'd1);
        check("level_in_done", 32'(level), 32'd1);
        tick();
        check("level_after_pop", 32'(level), 32'd0);
        check("out_valid_pulse", 32'(out_valid), 32'd0);
        repeat (3) tick();
        check("out_result_hold", out_result, 32'hFFFFFFF4);
        check("idle_no_req", 32'(req), 32'd0);

        // ack and result_rdy in the same cycle.
        push(16'h7FFF, 1'b1, 16'h7FFF, 1'b1);
        serve(0, 0, 32'h3FFF0001, 1'b1, 1'b0);
        check("same_cycle_done", 32'(out_valid), 32'd1);
        repeat (2) tick();

        // Fill while stalled; fifth push waits for the first completion.
        for (int i = 0; i < 4; i++) push(16'(16'h0010 + i), 1'b0, 16'(16'h0100 + i), 1'b1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(level), 32'd4);
        repeat (4) begin
            tick();
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_arg_a", 32'(arg_a), 32'h0010);
        end
        fork
            push(16'h0014, 1'b1, 16'h0104, 1'b0);
            serve(1, 1, 32'h0000_1000, 1'b0, 1'b0);
        join
        for (int i = 1; i < 5; i++) serve(0, 1, 32'(32'h1000 + i), 1'b1, 1'b0);
        tick();
        check("drain_level", 32'(level), 32'd0);

        // Push in the same cycle as the DONE pop keeps level unchanged.
        push(16'h0021, 1'b0, 16'h0022, 1'b0);
        push(16'h0023, 1'b0, 16'h0024, 1'b0);
        serve(0, 2, 32'h0000_0462, 1'b0, 1'b0);
        check("level_before_pushpop", 32'(level), 32'd2);
        in_valid = 1'b1; in_arg_a = 16'h0025; in_arg_b = 16'h0026;
        in_arg_a_parity = 1'b1; in_arg_b_parity = 1'b1;
        exp_ops.push_back('{a: 16'h0025, pa: 1'b1, b: 16'h0026, pb: 1'b1});
        tick();
        in_valid = 1'b0;
        check("level_pushpop", 32'(level), 32'd2);
        serve(0, 1, 32'h0000_0514, 1'b0, 1'b0);
        serve(0, 1, 32'h0000_05AE, 1'b1, 1'b0);
        tick();

        // Parity-error counting and saturation.
        for (int i = 0; i < 3; i++) begin
            push(16'(i + 1), 1'b1, 16'h0002, 1'b0);
            serve(0, 1, 32'(2 * (i + 1)), 1'b0, 1'b1);
        end
        repeat (2) tick();
        check("err_cnt_three", 32'(err_cnt), 32'd3);
        force dut.err_cnt_q = 16'hFFFE;
        tick();
        release dut.err_cnt_q;
        exp_err = 16'hFFFE;
        tick();
        check("err_cnt_forced", 32'(err_cnt), 32'h0000FFFE);
        for (int i = 0; i < 2; i++) begin
            push(16'h0001, 1'b1, 16'h0001, 1'b1);
            serve(0, 1, 32'h0000_0001, 1'b0, 1'b1);
        end
        repeat (2) tick();
        check("err_cnt_saturated", 32'(err_cnt), 32'h0000FFFF);

        // Reset while waiting for a result with two entries queued.
        push(16'h0031, 1'b0, 16'h0032, 1'b0);
        push(16'h0033, 1'b0, 16'h0034, 1'b0);
        wait_req();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("wait_res_level", 32'(level), 32'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_req", 32'(req), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_err_cnt", 32'(err_cnt), 32'd0);
        check("midrst_out_result", out_result, 32'd0);
        exp_ops.delete();
        exp_res.delete();
        exp_err = '0;
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        result_rdy = 1'b1; result = 32'h0000_0BEE;
        tick();
        result_rdy = 1'b0; result = '0;
        repeat (6) begin
            tick();
            check("late_result_no_out", 32'(out_valid), 32'd0);
            check("late_result_no_req", 32'(req), 32'd0);
        end

        check("ops_scoreboard_drained", 32'(exp_ops.size()), 32'd0);
        check("res_scoreboard_drained", 32'(exp_res.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_issue_queue.md
MULT_ISSUE_QUEUE -- requirements
Module: mult_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set operand-queue entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  producer offers an operand pair.
REQ-005 in_ready  output  1  queue can accept; transfer when in_valid && in_ready at a rising edge.
REQ-006 in_arg_a / in_arg_b  input  16 each  signed operands.
REQ-007 in_arg_a_parity / in_arg_b_parity  input  1 each  parity bits, passed through unmodified.
REQ-008 req  output  1  request to multiplier.
REQ-009 arg_a, arg_b  output  16 each; arg_a_parity, arg_b_parity  output  1 each  operands to multiplier.
REQ-010 ack  input  1  multiplier accepted operands (one-cycle pulse).
REQ-011 result_rdy  input  1  multiplier result valid (one-cycle pulse).
REQ-012 result  input  32; result_parity, arg_parity_error  input  1 each  multiplier outputs.
REQ-013 out_valid  output  1  one-cycle pulse: out_* hold a completed transaction.
REQ-014 out_result  output  32; out_result_parity, out_parity_error  output  1 each  registered copies.
REQ-015 level  output  $clog2(DEPTH+1)  current queue occupancy.
REQ-016 err_cnt  output  16  saturating count of completions with arg_parity_error=1.

Function
REQ-017 in_ready SHALL equal (level < DEPTH); push accepted when full SHALL NOT occur.
REQ-018 Queue SHALL be FIFO; push and pop in same cycle SHALL leave level unchanged; pointers wrap modulo DEPTH.
REQ-019 FSM states: IDLE, REQ, WAIT_RES, DONE.
REQ-020 IDLE -> REQ when level > 0; req=1 and arg_* driven from queue head from the first REQ cycle.
REQ-021 In REQ, req and arg_* SHALL stay stable until ack=1; on ack, req SHALL deassert the next cycle.
REQ-022 REQ -> WAIT_RES on ack without result_rdy; REQ -> DONE on ack && result_rdy same cycle.
REQ-023 WAIT_RES -> DONE on result_rdy; result, result_parity, arg_parity_error captured that edge.
REQ-024 result_rdy outside REQ/WAIT_RES SHALL be ignored; ack outside REQ SHALL be ignored.
REQ-025 DONE: out_valid=1 for exactly one cycle, queue head popped, err_cnt incremented if captured arg_parity_error=1 (saturate at 16'hFFFF); DONE -> IDLE.
REQ-026 Only one transaction outstanding; next req SHALL NOT assert earlier than the cycle after DONE.
REQ-027 Minimum latency: push at edge N into empty idle queue -> req=1 after edge N+1.
REQ-028 out_* SHALL hold last captured values between out_valid pulses.
REQ-029 Operand parity bits SHALL NOT be checked or regenerated by this block.

Reset
REQ-030 rst_n low SHALL immediately force: state=IDLE, req=0, arg_*=0, out_valid=0, out_*=0, level=0, err_cnt=0, pointers=0.
REQ-031 Reset mid-transaction SHALL discard queued and in-flight operands; no out_valid for them.
REQ-032 in_ready SHALL be 1 after the first edge following rst_n release.

Structure
REQ-033 mult_pkg SHALL hold operand_t struct {a, a_parity, b, b_parity}, issue_state_t enum, DEPTH default constant.
REQ-034 Queue storage SHALL be sub-module mult_op_fifo (push/pop/full/empty/level); FSM and output registers in mult_issue_queue.

Verification
REQ-035 Push (a=3,b=-4,parities even); ack 2 cycles after req, result_rdy 3 later with result=-12 -> one out_valid, out_result=32'hFFFFFFF4, level 1->0.
REQ-036 Push 5 pairs with DEPTH=4, multiplier stalled (no ack) -> in_ready=0 after 4th push, 5th held until first DONE; order preserved.
REQ-037 ack and result_rdy same cycle (a=16'sh7FFF,b=16'sh7FFF, result=32'h3FFF0001) -> REQ->DONE, single out_valid.
REQ-038 Three completions with arg_parity_error=1 -> err_cnt=3; force err_cnt near 16'hFFFF -> saturates.
REQ-039 rst_n low during WAIT_RES with 2 queued -> req=0, level=0 immediately; late result_rdy ignored, no out_valid.
REQ-040 Simultaneous push and DONE pop at level=2 -> level stays 2.
